// File: rtl/div_pkg.sv
// Shared types and widths for the sequential restoring divider.
package div_pkg;
    localparam int NUM_W = 8;
    localparam int DEN_W = 4;
    localparam int Q_W   = 4;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module div_step
    import div_pkg::*;
(
    input  logic [DEN_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [DEN_W-1:0] rem_o,
    output logic             q_o
);
    logic [DEN_W:0] t;
    logic [DEN_W:0] diff;

    always_comb begin
        t    = {rem_i, bit_i};
        diff = t - {1'b0, den_i};
        q_o  = (t >= {1'b0, den_i});
        // The difference is below den_i, so it always fits in DEN_W bits.
        rem_o = q_o ? diff[DEN_W-1:0] : t[DEN_W-1:0];
    end
endmodule

// File: rtl/div.sv
// Sequential unsigned divider, 8-bit by 4-bit, one quotient bit per clock.
module div
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] denom,
    input  logic             start,
    output logic [Q_W-1:0]   quotient,
    output logic [DEN_W-1:0] remainder,
    output logic             rdy,
    output logic             overflow
);
    div_state_e       state_q, state_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [DEN_W-1:0] r_q, r_d;
    logic [Q_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovp_q, ovp_d;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic             rdy_q, rdy_d;
    logic             ovf_q, ovf_d;

    logic [DEN_W-1:0] step_rem;
    logic             step_q;

    div_step u_step (
        .rem_i (r_q),
        .bit_i (num_q[cnt_q]),
        .den_i (den_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            den_q   <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovp_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovp_q   <= ovp_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        r_d     = r_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovp_d   = ovp_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        rdy_d   = rdy_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_d   = num;
                    den_d   = denom;
                    r_d     = num[NUM_W-1:NUM_W-DEN_W];
                    acc_d   = '0;
                    cnt_d   = CNT_W'(Q_W - 1);
                    // High nibble >= divisor means the quotient needs a fifth bit.
                    ovp_d   = (denom == '0) || (num[NUM_W-1:NUM_W-DEN_W] >= denom);
                    rdy_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (ovp_q) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    ovf_d   = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    r_d          = step_rem;
                    acc_d[cnt_q] = step_q;
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quo_d        = acc_q;
                        quo_d[0]     = step_q;
                        rem_d        = step_rem;
                        ovf_d        = 1'b0;
                        rdy_d        = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign rdy       = rdy_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_div.sv
// Directed-vector and exhaustive-sweep bench for the sequential divider.
module tb_div;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] num;
    logic [3:0] denom;
    logic       start;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       rdy;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .denom     (denom),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .rdy       (rdy),
        .overflow  (overflow)
    );

    typedef struct {
        logic [7:0] n;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic       ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start for one clock; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [7:0] n, input logic [3:0] d);
        @(negedge clk);
        num   = n;
        denom = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num   = 8'($urandom);
        denom = 4'($urandom);
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (!rdy && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rdy) chk("rdy_timeout", 32'(rdy), 32'd1);
    endtask

    vec_t vecs[9];
    int   lat;

    initial begin
        vecs[0] = '{8'h64, 4'h7, 4'hE, 4'h2, 1'b0};
        vecs[1] = '{8'hEF, 4'hF, 4'hF, 4'hE, 1'b0};
        vecs[2] = '{8'hF0, 4'hF, 4'h0, 4'h0, 1'b1};
        vecs[3] = '{8'h23, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[4] = '{8'h00, 4'h1, 4'h0, 4'h0, 1'b0};
        vecs[5] = '{8'h7F, 4'h8, 4'hF, 4'h7, 1'b0};
        vecs[6] = '{8'h80, 4'h8, 4'h0, 4'h0, 1'b1};
        vecs[7] = '{8'h32, 4'h5, 4'hA, 4'h0, 1'b0};
        vecs[8] = '{8'h0F, 4'h1, 4'hF, 4'h0, 1'b0};

        rst = 1'b0; num = '0; denom = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {rdy, overflow, quotient, remainder}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].n, vecs[i].d);
            chk($sformatf("v%0d_rdy_low_after_start", i), 32'(rdy), 32'd0);
            wait_rdy(lat);
            chk($sformatf("v%0d_result", i), {rdy, overflow, quotient, remainder},
                {1'b1, vecs[i].ov, vecs[i].q, vecs[i].r});
            if (vecs[i].ov) chk($sformatf("v%0d_ovf_latency", i), 32'(lat), 32'd1);
            else            chk($sformatf("v%0d_latency_le4", i), 32'(lat <= 4), 32'd1);
        end

        // Start during CALC is ignored.
        issue(8'h64, 4'h7);
        @(negedge clk);
        num = 8'h23; denom = 4'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rdy(lat);
        chk("start_in_calc_ignored", {rdy, overflow, quotient, remainder}, {1'b1, 1'b0, 4'hE, 4'h2});
        repeat (3) @(negedge clk);
        chk("hold_after_done", {rdy, overflow, quotient, remainder}, {1'b1, 1'b0, 4'hE, 4'h2});

        // New start after DONE: rdy drops, old values held, then new result.
        issue(8'hEF, 4'hF);
        chk("restart_rdy_drop_hold", {rdy, overflow, quotient, remainder}, {1'b0, 1'b0, 4'hE, 4'h2});
        wait_rdy(lat);
        chk("restart_result", {rdy, overflow, quotient, remainder}, {1'b1, 1'b0, 4'hF, 4'hE});

        // Reset mid-CALC aborts.
        issue(8'h64, 4'h7);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("reset_mid_calc", {rdy, overflow, quotient, remainder}, 32'h0);
        repeat (6) @(negedge clk);
        chk("idle_after_abort", 32'(rdy), 32'd0);

        // Start held high: back-to-back operations.
        @(negedge clk);
        num = 8'h23; denom = 4'h0; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("held_start_first", {rdy, overflow}, {1'b1, 1'b1});
        num = 8'h64; denom = 4'h7;
        @(negedge clk);
        chk("held_start_reaccept", 32'(rdy), 32'd0);
        start = 1'b0;
        wait_rdy(lat);
        chk("held_start_second", {rdy, overflow, quotient, remainder}, {1'b1, 1'b0, 4'hE, 4'h2});

        // Exhaustive sweep against a behavioural model.
        for (int n = 0; n < 256; n++) begin
            for (int d = 0; d < 16; d++) begin
                logic       eov;
                logic [3:0] eq, er;
                eov = (d == 0) || ((n / d) > 15);
                eq  = eov ? 4'h0 : 4'(n / d);
                er  = eov ? 4'h0 : 4'(n % d);
                issue(8'(n), 4'(d));
                repeat (14) @(negedge clk);
                chk($sformatf("sweep_%0d_%0d", n, d), {rdy, overflow, quotient, remainder},
                    {1'b1, eov, eq, er});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential unsigned restoring divider: 8-bit dividend by 4-bit divisor, giving a 4-bit quotient and a 4-bit remainder.
- One compare/subtract iteration per clock.
- Flags overflow when the divisor is zero or the quotient does not fit in 4 bits.
- Arithmetic leaf block driven by a one-cycle start pulse; consumers sample results when rdy is high.

Parameters:
- None. Widths are fixed: dividend 8, divisor 4, quotient 4, remainder 4.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge).
- num  input  8  unsigned dividend; sampled only on the start edge.
- denom  input  4  unsigned divisor; sampled only on the start edge.
- start  input  1  one-cycle request pulse.
- quotient  output  4  registered quotient.
- remainder  output  4  registered remainder.
- rdy  output  1  high while quotient, remainder and overflow are valid.
- overflow  output  1  high when the last operation overflowed; valid while rdy=1.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; quotient=0, remainder=0, rdy=0, overflow=0; internal registers cleared. Reset wins over start and aborts any operation in progress.
- States: IDLE, CALC, DONE. DONE behaves as IDLE but rdy=1.
- Start acceptance: start=1 at edge E0 while state is IDLE or DONE.
  - Latch num and denom; set rdy=0.
  - Evaluate overflow: denom==0 OR num[7:4] >= denom (equivalent to num/denom > 15).
- Overflow path: at E1, quotient=0, remainder=0, overflow=1, rdy=1, state=DONE.
- Normal path: overflow=0, state=CALC.
  - Partial remainder R (5 bits) initialised to {0,num[7:4]}.
  - Iteration at each of E1..E4, for k=3..0: T={R[3:0],num[k]}; if T>=denom then R=T-denom and q[k]=1, else R=T and q[k]=0.
  - At E4: quotient=q, remainder=R[3:0], rdy=1, state=DONE.
  - Worst-case latency from start edge to rdy=1 is 4 clocks; the bench samples 15 clocks later.
- Outputs hold their values until the next accepted start or reset. On acceptance they keep their old values, with rdy=0.
- start while in CALC is ignored; the operation in flight completes unchanged.
- start held high for several cycles: re-accepted at each IDLE/DONE edge (a new operation each time).
- Inputs num and denom may change freely after E0 without affecting the result.
- Invariants when overflow=0: num == quotient*denom + remainder, and remainder < denom.
- All logic uses the single clk domain and is synthesizable; there are no combinational paths from inputs to outputs.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE};
  - localparams NUM_W=8, DEN_W=4, Q_W=4;
  - a 2-bit iteration counter width.
- Sub-module div_step (combinational). Inputs: 4-bit partial remainder, next dividend bit, divisor. Outputs: new remainder and quotient bit.
- The top level holds the FSM, the operand latches, the iteration counter and the output registers.

Test Plan:
- Reset: rst=0 for 3 cycles, then release -> quotient=0, remainder=0, rdy=0, overflow=0.
- num=100 (0x64), denom=7, start pulse -> within 4 clocks rdy=1, quotient=0xE, remainder=0x2, overflow=0.
- Boundary: num=0xEF, denom=0xF -> quotient=0xF, remainder=0xE, overflow=0. Then num=0xF0, denom=0xF -> overflow=1, rdy=1, quotient=0, remainder=0.
- Divide by zero: num=0x23, denom=0 -> overflow=1 after 1 clock. Also num=0x00, denom=0x1 -> quotient=0, remainder=0, overflow=0.
- Control robustness:
  - start issued again during CALC is ignored (the first result is delivered);
  - rst=0 mid-CALC clears everything;
  - a new start after DONE drops rdy then delivers the new result.
- Exhaustive sweep of all 4096 {num,denom} pairs, 16 clocks apart, checked against a reference model:
  - overflow == (denom==0 || num/denom>15);
  - when no overflow, quotient == num/denom and remainder == num%denom.
